sisc_fetch: RTL
===============

Name: sisc_fetch

Overview:
- Instruction-fetch stage of the SISC core. It sits directly upstream of the control FSM.
- Owns the program counter (PC), the branch-target adder and the instruction register (IR).
- Reads instruction memory over a req/ack handshake and decodes IR fields into opcode/mm/register/immediate outputs.
- Controlled by the FSM signals pc_rst, pc_write, pc_sel, br_sel and ir_load. Reports outstanding fetches and timeouts back.

Parameters:
- PC_W, 16: PC, memory address and immediate width.
- INSTR_W, 32: instruction word width.
- TIMEOUT, 15: maximum cycles waiting for imem_ack before the fetch is aborted.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_rst  in  1  clear PC to 0.
- pc_write  in  1  PC load enable.
- pc_sel  in  1  0 = PC+1; 1 = branch target.
- br_sel  in  1  1 = absolute target (imm); 0 = relative target (PC+imm).
- ir_load  in  1  start a fetch at the current PC.
- imem_req  out  1  memory read request.
- imem_addr  out  PC_W  captured fetch address.
- imem_rdata  in  INSTR_W  read data, valid while imem_ack=1.
- imem_ack  in  1  one-cycle read completion.
- pc_out  out  PC_W  current PC.
- opcode  out  4  IR[31:28].
- mm  out  4  IR[27:24].
- rd, rs, rt  out  4 each  IR[23:20], IR[19:16], IR[15:12].
- imm  out  16  IR[15:0].
- ir_valid  out  1  IR holds a completed fetch.
- fetch_busy  out  1  fetch outstanding.
- fetch_err  out  1  sticky: timeout or overlapping ir_load.

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - pc=0, IR=0 (NOOP), state IDLE.
  - imem_req=0, imem_addr=0, ir_valid=0, fetch_busy=0, fetch_err=0, timeout counter=0.
  - Any in-flight fetch is abandoned; an imem_ack in the cycle after reset is ignored.
- PC update (every edge, independent of the fetch FSM), in priority order:
  - pc_rst: pc<=0.
  - else pc_write & !pc_sel: pc<=pc+1.
  - else pc_write & pc_sel & br_sel: pc<=imm.
  - else pc_write & pc_sel & !br_sel: pc<=pc+imm.
  - else hold.
  - Arithmetic is modulo 2^PC_W; imm is two's complement for relative branches; 0xFFFF+1 wraps to 0x0000.
- Fetch FSM states: IDLE, WAIT.
  - IDLE & ir_load: imem_addr<=pc (pre-update value, so a same-cycle pc_write increment does not affect the fetch); imem_req<=1; fetch_busy<=1; ir_valid<=0; cnt<=0; next state WAIT.
  - WAIT & imem_ack: IR<=imem_rdata; ir_valid<=1; imem_req<=0; fetch_busy<=0; next state IDLE. Latency from ir_load to ir_valid is 1 + memory wait cycles, minimum 2 cycles.
  - WAIT & !imem_ack: cnt<=cnt+1. When cnt reaches TIMEOUT-1: IR<=0 (NOOP); ir_valid<=1; fetch_err<=1; imem_req<=0; next state IDLE.
  - WAIT & ir_load: the request is ignored and fetch_err<=1. The current fetch continues.
- imem_req stays high and imem_addr stays stable for the whole WAIT state.
- imem_ack seen in IDLE is ignored: IR unchanged, no error.
- A branch (pc_write) during WAIT updates the PC only. The in-flight fetch still completes at its captured address.
- pc_rst during WAIT clears the PC only. The fetch is not cancelled; only rst cancels it.
- fetch_err clears only on rst.
- Decoded outputs are combinational from IR. rt and imm overlap by design (I-type vs R-type formats).

Decomposition:
- Shared package sisc_pkg contains:
  - opcode constants (NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU=8, HLT=15) and am_imm=8;
  - IR field bit positions and widths;
  - the fetch state enum.
- One sub-module, sisc_pc, holds the PC register, the +1 incrementer and the branch-target mux/adder.
- The top level holds the fetch FSM, timeout counter, IR and field decode.

Test Plan:
- Reset, then ir_load with ack after 2 wait cycles and rdata=0x8123_4005 -> imem_addr=0; ir_valid 3 cycles after ir_load; opcode=8, mm=1, rd=2, rs=3, imm=0x4005.
- ir_load together with pc_write=1, pc_sel=0 at pc=0x0007 -> imem_addr=0x0007, pc_out=0x0008.
- IR imm=0xFFFE with pc=0x0010, pc_write=1, pc_sel=1, br_sel=0 -> pc=0x000E. Same with br_sel=1 -> pc=0xFFFE. Then pc_write=1, pc_sel=0 twice -> pc goes 0xFFFF, then 0x0000.
- No ack for 15 cycles -> ir_valid=1, IR=0, fetch_err=1, imem_req=0. A late ack afterwards -> ignored.
- Second ir_load during WAIT -> fetch_err=1, imem_addr unchanged, first fetch completes normally.
- rst asserted mid-WAIT, with ack on the following cycle -> all outputs at reset values, IR stays 0, ir_valid=0.

Source files
------------

// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC core: opcodes, IR field layout, fetch states.
package sisc_pkg;

  localparam int SISC_PC_W    = 16;
  localparam int SISC_INSTR_W = 32;
  localparam int SISC_TIMEOUT = 15;

  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_LOD  = 4'd1;
  localparam logic [3:0] OP_STR  = 4'd2;
  localparam logic [3:0] OP_SWP  = 4'd3;
  localparam logic [3:0] OP_BRA  = 4'd4;
  localparam logic [3:0] OP_BRR  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_BNR  = 4'd7;
  localparam logic [3:0] OP_ALU  = 4'd8;
  localparam logic [3:0] OP_HLT  = 4'd15;
  localparam logic [3:0] AM_IMM  = 4'd8;

  // IR field layout; rt and imm overlap (R-type vs I-type formats)
  localparam int SISC_FLD_W  = 4;
  localparam int SISC_OPC_LSB = 28;
  localparam int SISC_MM_LSB  = 24;
  localparam int SISC_RD_LSB  = 20;
  localparam int SISC_RS_LSB  = 16;
  localparam int SISC_RT_LSB  = 12;
  localparam int SISC_IMM_LSB = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/sisc_pc.sv
// Program counter with +1 incrementer and absolute/relative branch-target mux.
module sisc_pc
  import sisc_pkg::*;
#(
  parameter int PC_W = SISC_PC_W
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_pc_rst,
  input  logic            i_pc_write,
  input  logic            i_pc_sel,
  input  logic            i_br_sel,
  input  logic [PC_W-1:0] i_imm,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_rel;
  logic [PC_W-1:0] w_pc_nxt;

  // Both adders wrap modulo 2^PC_W; imm is two's complement for relative branches.
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_pc_rel = r_pc + i_imm;

  // Next-PC select: clear beats write, increment beats branch.
  always_comb begin
    w_pc_nxt = r_pc;
    if (i_pc_rst) begin
      w_pc_nxt = '0;
    end else if (i_pc_write) begin
      if (!i_pc_sel)
        w_pc_nxt = w_pc_inc;
      else if (i_br_sel)
        w_pc_nxt = i_imm;
      else
        w_pc_nxt = w_pc_rel;
    end
  end

  // PC register.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_pc <= '0;
    else
      r_pc <= w_pc_nxt;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/sisc_fetch.sv
// SISC instruction-fetch stage: PC, imem req/ack fetch FSM with timeout, IR and field decode.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no fetch outstanding; ir_load captures PC and raises imem_req
//   ST_WAIT | request held at captured address until ack or timeout
module sisc_fetch
  import sisc_pkg::*;
#(
  parameter int PC_W    = SISC_PC_W,
  parameter int INSTR_W = SISC_INSTR_W,
  parameter int TIMEOUT = SISC_TIMEOUT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pc_rst,
  input  logic               i_pc_write,
  input  logic               i_pc_sel,
  input  logic               i_br_sel,
  input  logic               i_ir_load,
  output logic               o_imem_req,
  output logic [PC_W-1:0]    o_imem_addr,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  input  logic               i_imem_ack,
  output logic [PC_W-1:0]    o_pc_out,
  output logic [3:0]         o_opcode,
  output logic [3:0]         o_mm,
  output logic [3:0]         o_rd,
  output logic [3:0]         o_rs,
  output logic [3:0]         o_rt,
  output logic [PC_W-1:0]    o_imm,
  output logic               o_ir_valid,
  output logic               o_fetch_busy,
  output logic               o_fetch_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_t r_state, w_state_nxt;

  logic               r_req,   w_req_nxt;
  logic [PC_W-1:0]    r_addr,  w_addr_nxt;
  logic [INSTR_W-1:0] r_ir,    w_ir_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_busy,  w_busy_nxt;
  logic               r_err,   w_err_nxt;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
  logic [PC_W-1:0]    w_pc;

  // Branch offsets/targets come straight from the IR immediate field.
  sisc_pc #(.PC_W(PC_W)) u_pc (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_pc_rst   (i_pc_rst),
    .i_pc_write (i_pc_write),
    .i_pc_sel   (i_pc_sel),
    .i_br_sel   (i_br_sel),
    .i_imm      (o_imm),
    .o_pc       (w_pc)
  );

  // Fetch FSM next-state and next-register values; everything holds unless a rule fires.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_ir_nxt    = r_ir;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        // Capture the pre-update PC so a same-cycle pc_write cannot skew the fetch.
        if (i_ir_load) begin
          w_addr_nxt  = w_pc;
          w_req_nxt   = 1'b1;
          w_busy_nxt  = 1'b1;
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_ir_load)
          w_err_nxt = 1'b1;
        if (i_imem_ack) begin
          w_ir_nxt    = i_imem_rdata;
          w_valid_nxt = 1'b1;
          w_req_nxt   = 1'b0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          // Abort: hand the control FSM a NOOP and flag the error.
          w_ir_nxt    = '0;
          w_valid_nxt = 1'b1;
          w_err_nxt   = 1'b1;
          w_req_nxt   = 1'b0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Fetch datapath registers; rst abandons any in-flight fetch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_ir    <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
      r_ir    <= w_ir_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_imem_req   = r_req;
  assign o_imem_addr  = r_addr;
  assign o_pc_out     = w_pc;
  assign o_ir_valid   = r_valid;
  assign o_fetch_busy = r_busy;
  assign o_fetch_err  = r_err;

  assign o_opcode = r_ir[SISC_OPC_LSB +: SISC_FLD_W];
  assign o_mm     = r_ir[SISC_MM_LSB  +: SISC_FLD_W];
  assign o_rd     = r_ir[SISC_RD_LSB  +: SISC_FLD_W];
  assign o_rs     = r_ir[SISC_RS_LSB  +: SISC_FLD_W];
  assign o_rt     = r_ir[SISC_RT_LSB  +: SISC_FLD_W];
  assign o_imm    = r_ir[SISC_IMM_LSB +: PC_W];

endmodule
